uart_rx_fifo: RTL

Receive buffer that sits directly downstream of the UART receiver. It captures each byte the receiver reports through its one-cycle `data_ready` strobe and stores the bytes in a first-word-fall-through FIFO. Bytes are presented to the consumer (command decoder or bus bridge) on a valid/ready handshake. It also provides overflow detection and a line-idle timeout that marks message boundaries.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_idle_timer.sv | 62 ++++++
 rtl/uart_rx_fifo.sv | 108 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte type, idle-timer width and the stop-bit
// encoding used by the receiver configuration.
package uart_pkg;

  typedef logic [7:0] uart_byte_t;

  localparam int UART_TIMEOUT_W = 16;

  typedef enum logic [1:0] {
    UART_STOP_1   = 2'd0,
    UART_STOP_1P5 = 2'd1,
    UART_STOP_2   = 2'd2
  } uart_stopbits_e;

endpackage

// File: rtl/uart_idle_timer.sv
// Line-idle timer. A kick clears the counter and arms it. While armed, the
// counter advances once per cycle. When it reaches the timeout, one
// idle_pulse is emitted and the timer disarms until the next kick.
// A zero timeout keeps the timer cleared and disarmed.
module uart_idle_timer
  import uart_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      kick,
  input  logic [UART_TIMEOUT_W-1:0] timeout,
  output logic                      idle_pulse
);

  logic [UART_TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [UART_TIMEOUT_W-1:0] cnt_inc;
  logic                      armed_q, armed_d;
  logic                      pulse_q, pulse_d;

  // Next-state logic: clear/arm on kick, count while armed, fire and disarm on match.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    pulse_d = 1'b0;
    cnt_inc = cnt_q + {{(UART_TIMEOUT_W-1){1'b0}}, 1'b1};
    if (timeout == {UART_TIMEOUT_W{1'b0}}) begin
      cnt_d   = {UART_TIMEOUT_W{1'b0}};
      armed_d = 1'b0;
    end else if (kick) begin
      cnt_d   = {UART_TIMEOUT_W{1'b0}};
      armed_d = 1'b1;
    end else if (armed_q) begin
      cnt_d = cnt_inc;
      // Matching on the incremented value registers the pulse so it
      // appears timeout+1 cycles after the kick cycle.
      if (cnt_inc == timeout) begin
        pulse_d = 1'b1;
        armed_d = 1'b0;
      end else begin
        pulse_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Timer state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= {UART_TIMEOUT_W{1'b0}};
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      pulse_q <= pulse_d;
    end
  end

  assign idle_pulse = pulse_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures one byte per rising edge of the receiver's
// data_ready strobe into a first-word-fall-through FIFO, exposes it on a
// valid/ready handshake, flags dropped bytes and marks idle-line gaps.
// rst must be deasserted synchronously to clk by the surrounding system.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                rx_data,
  input  logic                      rx_strobe,
  input  logic [UART_TIMEOUT_W-1:0] idle_timeout,
  input  logic                      clear_overflow,
  output logic [7:0]                out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      overflow,
  output logic                      line_idle
);

  localparam int              PW      = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0]   PTR_ONE = PW'(1);
  localparam logic [PW-1:0]   CNT_MAX = PW'(DEPTH);

  uart_byte_t    mem_q [DEPTH];
  uart_byte_t    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          strobe_q, strobe_d;
  logic          ovf_q, ovf_d;

  logic          wr_evt;
  logic          rd_evt;
  logic          wr_acc;
  logic          drop;

  // Occupancy comes from the pointer difference; the extra MSB separates full from empty.
  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = (count == CNT_MAX);
  assign out_valid = (count != {PW{1'b0}});
  assign out_data  = out_valid ? mem_q[rd_ptr_q[PW-2:0]] : 8'h00;
  assign overflow  = ovf_q;

  // A held strobe counts once; a write while full is kept only if a read frees a slot.
  assign wr_evt = rx_strobe & ~strobe_q;
  assign rd_evt = out_valid & out_ready;
  assign wr_acc = wr_evt & (~full | rd_evt);
  assign drop   = wr_evt & full & ~rd_evt;

  // Next-state logic for storage, pointers, strobe history and sticky overflow.
  always_comb begin
    strobe_d = rx_strobe;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (wr_acc) begin
      mem_d[wr_ptr_q[PW-2:0]] = rx_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_evt) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // A new drop outranks a clear in the same cycle.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_overflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO state registers, cleared asynchronously so a reset discards everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: 8'h00};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      strobe_q <= strobe_d;
      ovf_q    <= ovf_d;
    end
  end

  // Every write edge, including dropped ones, restarts the idle timer.
  uart_idle_timer u_idle_timer (
    .clk        (clk),
    .rst        (rst),
    .kick       (wr_evt),
    .timeout    (idle_timeout),
    .idle_pulse (line_idle)
  );

endmodule
